// File: rtl/addsub_seq_if.sv
// Handshake/operand/flag bundle for addsub_seq.
// The acc select only exists when ADDSUB_SEQ_ACC_EN is defined.
interface addsub_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef ADDSUB_SEQ_ACC_EN
    logic             acc;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport master (
        output start, mode, a, b,
`ifdef ADDSUB_SEQ_ACC_EN
        output acc,
`endif
        input  busy, done, result, carry, overflow, zero, negative
    );

    modport slave (
        input  start, mode, a, b,
`ifdef ADDSUB_SEQ_ACC_EN
        input  acc,
`endif
        output busy, done, result, carry, overflow, zero, negative
    );
endinterface

// File: rtl/addsub_seq.sv
// Multi-cycle two's-complement adder/subtractor, CHUNK bits per clock.
// Optional accumulate source (result register as operand A) under ADDSUB_SEQ_ACC_EN.
module addsub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic        clk,
    input logic        rst,
    addsub_seq_if.slave bus
);
    localparam int L     = WIDTH / CHUNK;
    localparam int IDX_W = (L > 1) ? $clog2(L) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(L - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] op_a, op_b, result_q, res_nxt, src_a;
    logic [IDX_W-1:0] idx;
    logic             cy;
    logic             carry_q, ovf_q, zero_q, neg_q;
    logic             accept, last, msb_cin;
    logic [CHUNK-1:0] sl_a, sl_b;
    logic [CHUNK:0]   slice_sum;

    // A new op is taken whenever the unit is not mid-computation.
    assign accept = (state != RUN) && bus.start;
    assign last   = (idx == LAST);

`ifdef ADDSUB_SEQ_ACC_EN
    assign src_a = bus.acc ? result_q : bus.a;
`else
    assign src_a = bus.a;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last)   state_nxt = DONE;
            DONE:    state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sl_a      = op_a[idx*CHUNK +: CHUNK];
        sl_b      = op_b[idx*CHUNK +: CHUNK];
        slice_sum = {1'b0, sl_a} + {1'b0, sl_b} + {{CHUNK{1'b0}}, cy};
        // Carry into the slice MSB recovered from its sum bit: a ^ b ^ cin.
        msb_cin   = sl_a[CHUNK-1] ^ sl_b[CHUNK-1] ^ slice_sum[CHUNK-1];
        res_nxt   = result_q;
        res_nxt[idx*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            idx      <= '0;
            cy       <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else if (accept) begin
            op_a <= src_a;
            op_b <= bus.b ^ {WIDTH{bus.mode}};
            cy   <= bus.mode;
            idx  <= '0;
        end else if (state == RUN) begin
            result_q <= res_nxt;
            cy       <= slice_sum[CHUNK];
            idx      <= idx + IDX_W'(1);
            if (last) begin
                carry_q <= slice_sum[CHUNK];
                ovf_q   <= msb_cin ^ slice_sum[CHUNK];
                zero_q  <= (res_nxt == '0);
                neg_q   <= res_nxt[WIDTH-1];
            end
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.result   = result_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;
    assign bus.negative = neg_q;
endmodule

// File: tb/tb_addsub_seq.sv
// Randomized self-checking bench for addsub_seq against an arithmetic reference model.
// Accumulate cases run only when ADDSUB_SEQ_ACC_EN is defined.
module tb_addsub_seq;
    localparam int W     = 16;
    localparam int CHUNK = 4;
    localparam int L     = W / CHUNK;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [W-1:0] mdl_res = '0;

    always #5 clk = ~clk;

    addsub_seq_if #(.WIDTH(W)) bus ();

    addsub_seq #(.WIDTH(W), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                         output logic [W-1:0] r, output logic c, output logic v,
                         output logic z, output logic n);
        int sa, sb, sr;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (!m) begin
            r  = a + b;
            c  = ({1'b0, a} + {1'b0, b}) > 17'h0FFFF;
            sr = sa + sb;
        end else begin
            r  = a - b;
            c  = (a >= b);
            sr = sa - sb;
        end
        v = (sr > 32767) || (sr < -32768);
        z = (r == '0);
        n = r[W-1];
    endtask

    task automatic check_flags(input string tag, input logic [W-1:0] r, input logic c,
                               input logic v, input logic z, input logic n);
        check({tag, ".result"},   32'(bus.result), 32'(r));
        check({tag, ".carry"},    32'(bus.carry), 32'(c));
        check({tag, ".overflow"}, 32'(bus.overflow), 32'(v));
        check({tag, ".zero"},     32'(bus.zero), 32'(z));
        check({tag, ".negative"}, 32'(bus.negative), 32'(n));
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                         input logic accv);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.mode  = m;
`ifdef ADDSUB_SEQ_ACC_EN
        bus.acc   = accv;
`else
        if (accv) $display("note: acc requested without accumulate support");
`endif
    endtask

    // Issue one op, wait for done (bounded), check latency, busy length and outputs.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic m, input logic accv, input logic full);
        logic [W-1:0] r, opa;
        logic c, v, z, n;
        int lat, bcnt;
        @(negedge clk);
        drive(a, b, m, accv);
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        bcnt = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        opa = accv ? mdl_res : a;
        model(opa, b, m, r, c, v, z, n);
        mdl_res = r;
        if (full) begin
            check({tag, ".latency"}, 32'(lat), 32'(L));
            check({tag, ".busy_cycles"}, 32'(bcnt), 32'(L));
        end else begin
            check({tag, ".done_seen"}, 32'(bus.done), 32'd1);
        end
        check_flags(tag, r, c, v, z, n);
        @(posedge clk); #1;
        if (full) check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        logic [W-1:0] r;
        logic c, v, z, n;
        int cnt;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.mode  = 1'b0;
`ifdef ADDSUB_SEQ_ACC_EN
        bus.acc   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset.busy", 32'(bus.busy), 32'd0);
        check("reset.done", 32'(bus.done), 32'd0);
        check_flags("reset", '0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Directed cases
        do_op("add_small", 16'h0005, 16'h0003, 1'b0, 1'b0, 1'b1);
        do_op("sub_pos",   16'h0005, 16'h0003, 1'b1, 1'b0, 1'b1);
        do_op("sub_neg",   16'h0003, 16'h0005, 1'b1, 1'b0, 1'b1);
        do_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        do_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        do_op("sub_ovf",   16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1);

        // A second start during RUN must be ignored
        @(negedge clk);
        drive(16'h1234, 16'h0101, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        cnt = 0;
        while (!bus.done && cnt < 100) begin
            if (cnt == 1) drive(16'hAAAA, 16'h5555, 1'b1, 1'b0);
            if (cnt == 2) bus.start = 1'b0;
            @(posedge clk); #1;
            cnt++;
        end
        check("ignore.latency", 32'(cnt), 32'(L));
        model(16'h1234, 16'h0101, 1'b0, r, c, v, z, n);
        check_flags("ignore", r, c, v, z, n);

        // Start held in the DONE cycle is accepted back-to-back
        drive(16'h0100, 16'h0200, 1'b1, 1'b0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        cnt = 1;
        while (!bus.done && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("b2b.spacing", 32'(cnt), 32'(L + 1));
        model(16'h0100, 16'h0200, 1'b1, r, c, v, z, n);
        check_flags("b2b", r, c, v, z, n);
        mdl_res = r;
        @(posedge clk); #1;

        // Reset in the middle of RUN aborts without a done pulse
        @(negedge clk);
        drive(16'h4321, 16'h1111, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mdl_res = '0;
        check("abort.busy", 32'(bus.busy), 32'd0);
        check("abort.done", 32'(bus.done), 32'd0);
        check_flags("abort", '0, 1'b0, 1'b0, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < L + 3; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) cnt++;
        end
        check("abort.no_done", 32'(cnt), 32'd0);
        do_op("after_abort", 16'h4321, 16'h1111, 1'b0, 1'b0, 1'b1);

`ifdef ADDSUB_SEQ_ACC_EN
        do_op("acc_seed", 16'h0005, 16'h0003, 1'b0, 1'b0, 1'b1);
        do_op("acc_dec",  16'hDEAD, 16'h0008, 1'b1, 1'b1, 1'b1);
        check("acc_dec.zero_direct", 32'(bus.zero), 32'd1);
`endif

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic rm, racc;
            ra = W'($urandom);
            rb = W'($urandom);
            rm = 1'($urandom);
            racc = 1'b0;
`ifdef ADDSUB_SEQ_ACC_EN
            racc = 1'($urandom);
`endif
            if (i % 8 == 0) ra = {1'b0, {(W-1){1'b1}}};
            do_op($sformatf("rand%0d", i), ra, rb, rm, racc, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
- Parametrised, multi-cycle two's-complement adder/subtractor.
- Processes a WIDTH-bit operation in CHUNK-bit slices, one slice per clock. The carry is held in a register between slices.
- Uses a start/busy/done handshake and reports carry, signed overflow, zero and negative flags.
- Sits in the datapath library as the area-reduced successor to the fixed 4-bit combinational add/sub block.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be ≥ 2 and a multiple of CHUNK.
- CHUNK, 4, bits computed per cycle. 1 gives bit-serial operation; CHUNK = WIDTH gives a single-cycle RUN.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new operation; sampled only when not busy
- mode  input  1  0 = a+b, 1 = a−b; captured on accepted start
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- busy  output  1  high while a slice computation is in progress
- done  output  1  one-cycle pulse when the result becomes valid
- result  output  WIDTH  sum/difference; held until the next accepted start
- carry  output  1  carry out of the MSB; for subtract, 1 = no borrow (a ≥ b unsigned)
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB
- zero  output  1  result == 0
- negative  output  1  result[WIDTH-1]

Behaviour:
- FSM states: IDLE, RUN, DONE. On rst: state=IDLE; busy, done, result, carry, overflow, zero, negative all 0; slice index=0.
- IDLE or DONE, start=1 (accept):
  - latch A=a and B'=b XOR {WIDTH{mode}};
  - set carry register = mode;
  - slice index = 0; state=RUN; busy=1 from the next cycle.
  - Flags and result from the previous op remain readable until overwritten.
- DONE, start=0: return to IDLE.
- DONE always lasts exactly one cycle.
- RUN, each cycle:
  - compute slice k = A[k·CHUNK +: CHUNK] + B'[same] + carry;
  - write the slice into result;
  - update the carry register;
  - on the last slice, also record the carry into the MSB for overflow.
- Last slice (k = WIDTH/CHUNK − 1): after that edge, state=DONE, busy=0, done=1, and carry/overflow/zero/negative update together with the final result.
- Latency: with L = WIDTH/CHUNK and start accepted at edge 0, done is high after edge L and result is valid in that same cycle. Back-to-back throughput is one op per L+1 cycles (start accepted in DONE).
- start while busy: ignored. No queuing, and operands are not re-sampled.
- Intermediate result bits during RUN are undefined to consumers. Sample result only when done=1 or while idle.
- rst mid-RUN: abort immediately and return to the reset values. No done pulse is produced for the aborted op.
- rst and start in the same cycle: rst wins.
- All arithmetic is modulo 2^WIDTH. No saturation.

Optional Feature:
- Macro ADDSUB_SEQ_ACC_EN.
- Defined:
  - extra input port acc (1 bit), captured on accepted start;
  - acc=1 replaces operand A with the current result register, giving a running accumulate/decrement;
  - acc=0 behaves as normal;
  - after reset the accumulator source is 0.
- Undefined: no acc port; A is always taken from port a.

Test Plan (WIDTH=16, CHUNK=4, L=4):
- a=0x0005, b=0x0003, mode=0, start pulse → done exactly 4 cycles after the start edge; result=0x0008; carry=0, overflow=0, zero=0, negative=0; busy high for 4 cycles.
- a=0x0005, b=0x0003, mode=1 → result=0x0002, carry=1. Then a=0x0003, b=0x0005, mode=1 → result=0xFFFE, carry=0, negative=1, overflow=0.
- a=0x7FFF, b=0x0001, mode=0 → result=0x8000, overflow=1, carry=0. Then a=0xFFFF, b=0x0001, mode=0 → result=0x0000, carry=1, zero=1, overflow=0.
- Start accepted, second start with different operands asserted at cycle 2 → ignored; first result returned. A start held high in the DONE cycle is accepted back-to-back, and its done arrives 5 cycles after the previous done.
- rst asserted at cycle 2 of RUN → next cycle busy=0, done=0, result=0x0000, all flags 0. No done pulse follows. The next op completes normally.
- (ADDSUB_SEQ_ACC_EN) 0x0005+0x0003 → 0x0008. Then acc=1, mode=1, b=0x0008 → 0x0000 with zero=1, carry=1. Repeat with CHUNK=1 and check done arrives 16 cycles after start.
